sha1_block_feeder: RTL and testbench

- Avalon-MM slave that buffers one 512-bit SHA-1 message block (16 x 32-bit words) written by the HPS.
- On a GO command it streams the block word-by-word into the SHA-1 pipeline input with a valid/ready handshake.
- Tracks blocks in flight (sent but not yet completed) and exports that count as a 4-bit value to the soc_system input PIO that reports in-flight count.
- Stalls submission when the pipeline is at its in-flight limit.

---
 rtl/sha1_block_feeder.sv | 212 +++++++++++++++++++++
 tb/tb_sha1_block_feeder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_block_feeder.sv
// sha1_block_feeder: Avalon-MM slave holding one 512-bit SHA-1 message block.
// The HPS fills the 16-word buffer and issues GO. The block is then streamed
// word-by-word into the SHA-1 pipeline over a valid/ready handshake. The
// number of blocks in flight is counted and exported for the in-flight PIO.
//
// Register map (word addresses):
//   0-15  message buffer (write only, ignored unless IDLE)
//   16    control: bit0=1 issues GO
//   17    status read / bit0=1 write clears the error flags
//   18-31 unused, writes ignored, reads return 0

module sha1_block_feeder #(
    parameter int WORD_W       = 32,
    parameter int WORDS        = 16,
    parameter int CNT_W        = 4,
    parameter int MAX_INFLIGHT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [4:0]        avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    output logic              pipe_valid,
    output logic [WORD_W-1:0] pipe_data,
    output logic              pipe_last,
    input  logic              pipe_ready,
    input  logic              done_pulse,
    output logic [CNT_W-1:0]  in_count,
    output logic              busy
);

    localparam int               IDX_W     = $clog2(WORDS);
    localparam logic [4:0]       ADDR_CTRL = 5'd16;
    localparam logic [4:0]       ADDR_STAT = 5'd17;
    localparam logic [4:0]       ADDR_BUFN = 5'(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_inc;
    logic [WORD_W-1:0]   blk_buf [WORDS];

    logic                wr_err;
    logic                uf_err;

    logic                buf_wr;
    logic                go_wr;
    logic                clr_wr;
    logic                illegal_wr;
    logic                accept;
    logic                accept_last;
    logic                uf_event;
    logic [CNT_W-1:0]    count_next;
    logic [31:0]         status_word;

    // The read mux updates every cycle regardless of the strobe, so the
    // strobe itself carries no information for this slave.
    logic                unused_read;
    assign unused_read = avs_read;

    assign busy = (state == SEND) || (state == STALL);

    // Decode the Avalon write and the pipeline handshake for this cycle.
    always_comb begin
        buf_wr      = avs_write && (avs_address < ADDR_BUFN);
        go_wr       = avs_write && (avs_address == ADDR_CTRL) && avs_writedata[0];
        clr_wr      = avs_write && (avs_address == ADDR_STAT) && avs_writedata[0];
        illegal_wr  = (buf_wr || go_wr) && (state != IDLE);
        accept      = pipe_valid && pipe_ready;
        accept_last = accept && (idx == LAST_IDX);
        idx_inc     = idx + IDX_ONE;
    end

    // Next in-flight count: a completed send and a retirement in the same
    // cycle cancel; a retirement with nothing in flight is an underflow.
    always_comb begin
        count_next = in_count;
        uf_event   = 1'b0;
        if (accept_last && !done_pulse) begin
            count_next = in_count + CNT_ONE;
        end else if (done_pulse && !accept_last) begin
            if (in_count == '0) begin
                uf_event = 1'b1;
            end else begin
                count_next = in_count - CNT_ONE;
            end
        end
    end

    // In-flight block counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_count <= '0;
        end else begin
            in_count <= count_next;
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_err <= 1'b0;
            uf_err <= 1'b0;
        end else begin
            if (illegal_wr) begin
                wr_err <= 1'b1;
            end else if (clr_wr) begin
                wr_err <= 1'b0;
            end
            if (uf_event) begin
                uf_err <= 1'b1;
            end else if (clr_wr) begin
                uf_err <= 1'b0;
            end
        end
    end

    // Message buffer: accepts HPS writes only while IDLE, never reset.
    always_ff @(posedge clk) begin
        if (reset_n && buf_wr && (state == IDLE)) begin
            blk_buf[avs_address[IDX_W-1:0]] <= avs_writedata;
        end
    end

    // Feeder FSM with registered pipeline outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            pipe_valid <= 1'b0;
            pipe_last  <= 1'b0;
            pipe_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go_wr) begin
                        if (in_count < CNT_MAX) begin
                            state      <= SEND;
                            idx        <= '0;
                            pipe_valid <= 1'b1;
                            pipe_data  <= blk_buf[0];
                            pipe_last  <= 1'b0;
                        end else begin
                            state      <= STALL;
                        end
                    end
                end
                STALL: begin
                    if (count_next < CNT_MAX) begin
                        state      <= SEND;
                        idx        <= '0;
                        pipe_valid <= 1'b1;
                        pipe_data  <= blk_buf[0];
                        pipe_last  <= 1'b0;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (idx == LAST_IDX) begin
                            state      <= IDLE;
                            idx        <= '0;
                            pipe_valid <= 1'b0;
                            pipe_last  <= 1'b0;
                        end else begin
                            idx        <= idx_inc;
                            pipe_data  <= blk_buf[idx_inc];
                            pipe_last  <= (idx_inc == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    idx        <= '0;
                    pipe_valid <= 1'b0;
                    pipe_last  <= 1'b0;
                end
            endcase
        end
    end

    // Status word assembled from the current register values.
    always_comb begin
        status_word              = '0;
        status_word[CNT_W-1:0]   = in_count;
        status_word[5:4]         = state;
        status_word[8]           = wr_err;
        status_word[9]           = uf_err;
    end

    // Registered read data, one cycle behind the address.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            avs_readdata <= '0;
        end else if (avs_address == ADDR_STAT) begin
            avs_readdata <= status_word;
        end else begin
            avs_readdata <= '0;
        end
    end

endmodule

// File: tb/tb_sha1_block_feeder.sv
// tb_sha1_block_feeder: table-driven block submissions plus hand-written
// sequences for stall, counter corner cases, illegal writes and reset.
// Words expected on the pipeline are queued when GO is issued and popped
// as the handshake accepts them.

module tb_sha1_block_feeder;

    logic        clk;
    logic        reset_n;
    logic [4:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        pipe_valid;
    logic [31:0] pipe_data;
    logic        pipe_last;
    logic        pipe_ready;
    logic        done_pulse;
    logic [3:0]  in_count;
    logic        busy;

    typedef struct {
        logic [31:0] base;
        int          mode;
        int          cycles;
        logic        done_last;
        logic [3:0]  cnt;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_buf [16];
    word_t       exp_q [$];
    vec_t        vecs [4];

    logic        prev_stalled = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    sha1_block_feeder dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .pipe_valid    (pipe_valid),
        .pipe_data     (pipe_data),
        .pipe_last     (pipe_last),
        .pipe_ready    (pipe_ready),
        .done_pulse    (done_pulse),
        .in_count      (in_count),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    // Scoreboard and hold monitor, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (reset_n && prev_stalled) begin
            checkOutput("hold_valid", {31'b0, pipe_valid}, 32'h1);
            checkOutput("hold_data", pipe_data, prev_data);
            checkOutput("hold_last", {31'b0, pipe_last}, {31'b0, prev_last});
        end
        prev_stalled = reset_n && pipe_valid && !pipe_ready;
        prev_data    = pipe_data;
        prev_last    = pipe_last;
        if (reset_n && pipe_valid && pipe_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_word", pipe_data, 32'hFFFF_FFFF);
            end else begin
                word_t w;
                w = exp_q.pop_front();
                checkOutput("word_data", pipe_data, w.data);
                checkOutput("word_last", {31'b0, pipe_last}, {31'b0, w.last});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    task automatic readStatus(output logic [31:0] value);
        avs_address = 5'd17;
        tick();
        value = avs_readdata;
    endtask

    task automatic loadBlock(input logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            writeReg(5'(i), base + 32'(i));
            exp_buf[i] = base + 32'(i);
        end
    endtask

    task automatic pushBlock();
        for (int i = 0; i < 16; i++) begin
            word_t w;
            w.data = exp_buf[i];
            w.last = (i == 15);
            exp_q.push_back(w);
        end
    endtask

    // Mode 0: ready held high. Mode 1: ready alternates low, high, ...
    task automatic runSend(input int mode, input logic done_last, output int cycles);
        cycles = 0;
        while (pipe_valid && cycles < 200) begin
            pipe_ready = (mode == 0) ? 1'b1 : (cycles % 2 == 1);
            done_pulse = done_last && pipe_last && pipe_ready;
            tick();
            done_pulse = 1'b0;
            cycles++;
        end
        pipe_ready = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        int cycles;
        pushBlock();
        writeReg(5'd16, 32'h1);
        checkOutput("go_latency", {31'b0, pipe_valid}, 32'h1);
        checkOutput("busy_send", {31'b0, busy}, 32'h1);
        runSend(v.mode, v.done_last, cycles);
        checkOutput("send_cycles", 32'(cycles), 32'(v.cycles));
        checkOutput("valid_drop", {31'b0, pipe_valid}, 32'h0);
        checkOutput("in_count", {28'b0, in_count}, {28'b0, v.cnt});
        checkOutput("queue_empty", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        logic [31:0] st;
        int          cycles;
        vec_t        v;

        vecs[0] = '{base: 32'h0000_1000, mode: 0, cycles: 16, done_last: 1'b0, cnt: 4'd1};
        vecs[1] = '{base: 32'h0000_1000, mode: 1, cycles: 32, done_last: 1'b0, cnt: 4'd2};
        vecs[2] = '{base: 32'hA5A5_0000, mode: 0, cycles: 16, done_last: 1'b0, cnt: 4'd3};
        vecs[3] = '{base: 32'h0000_3000, mode: 0, cycles: 16, done_last: 1'b1, cnt: 4'd3};

        reset_n       = 1'b0;
        avs_address   = '0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        avs_read      = 1'b0;
        pipe_ready    = 1'b0;
        done_pulse    = 1'b0;
        tick();
        tick();
        checkOutput("rst_valid", {31'b0, pipe_valid}, 32'h0);
        checkOutput("rst_last", {31'b0, pipe_last}, 32'h0);
        checkOutput("rst_count", {28'b0, in_count}, 32'h0);
        checkOutput("rst_readdata", avs_readdata, 32'h0);
        checkOutput("rst_busy", {31'b0, busy}, 32'h0);
        reset_n  = 1'b1;
        avs_read = 1'b1;
        readStatus(st);
        checkOutput("rst_status", st, 32'h0);

        $display("[TB] block submissions from table");
        for (int i = 0; i < 4; i++) begin
            loadBlock(vecs[i].base);
            applyStimulus(vecs[i]);
            readStatus(st);
            checkOutput("status_idle", st, {28'b0, vecs[i].cnt});
        end

        $display("[TB] counter drain and underflow");
        done_pulse = 1'b1;
        tick();
        checkOutput("drain_2", {28'b0, in_count}, 32'd2);
        tick();
        checkOutput("drain_1", {28'b0, in_count}, 32'd1);
        tick();
        checkOutput("drain_0", {28'b0, in_count}, 32'd0);
        tick();
        checkOutput("uf_count", {28'b0, in_count}, 32'd0);
        done_pulse = 1'b0;
        readStatus(st);
        checkOutput("uf_status", st, 32'h200);
        writeReg(5'd17, 32'h1);
        readStatus(st);
        checkOutput("uf_clear", st, 32'h0);
        done_pulse = 1'b1;
        writeReg(5'd17, 32'h1);
        done_pulse = 1'b0;
        readStatus(st);
        checkOutput("uf_set_wins", st, 32'h200);
        writeReg(5'd17, 32'h1);
        readStatus(st);
        checkOutput("uf_clear2", st, 32'h0);

        $display("[TB] ignored writes and stall");
        loadBlock(32'h0000_4000);
        writeReg(5'd20, 32'h1);
        writeReg(5'd31, 32'hFFFF_FFFF);
        writeReg(5'd16, 32'h2);
        checkOutput("no_go_valid", {31'b0, pipe_valid}, 32'h0);
        checkOutput("no_go_busy", {31'b0, busy}, 32'h0);
        readStatus(st);
        checkOutput("ignored_status", st, 32'h0);
        for (int i = 0; i < 15; i++) begin
            v = '{base: 32'h0000_4000, mode: 0, cycles: 16, done_last: 1'b0, cnt: 4'(i + 1)};
            applyStimulus(v);
        end
        pushBlock();
        writeReg(5'd16, 32'h1);
        checkOutput("stall_valid", {31'b0, pipe_valid}, 32'h0);
        checkOutput("stall_busy", {31'b0, busy}, 32'h1);
        checkOutput("stall_count", {28'b0, in_count}, 32'd15);
        readStatus(st);
        checkOutput("stall_status", st, 32'h2F);
        tick();
        checkOutput("stall_hold", {31'b0, pipe_valid}, 32'h0);
        done_pulse = 1'b1;
        tick();
        done_pulse = 1'b0;
        checkOutput("unstall_count", {28'b0, in_count}, 32'd14);
        checkOutput("unstall_valid", {31'b0, pipe_valid}, 32'h1);
        runSend(0, 1'b0, cycles);
        checkOutput("unstall_cycles", 32'(cycles), 32'd16);
        checkOutput("unstall_final", {28'b0, in_count}, 32'd15);
        checkOutput("unstall_queue", 32'(exp_q.size()), 32'h0);
        done_pulse = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        done_pulse = 1'b0;
        readStatus(st);
        checkOutput("drain_status", st, 32'h0);

        $display("[TB] buffer write during send");
        loadBlock(32'h0000_5000);
        pushBlock();
        writeReg(5'd16, 32'h1);
        writeReg(5'd4, 32'hDEAD_BEEF);
        runSend(0, 1'b0, cycles);
        checkOutput("wr_err_cycles", 32'(cycles), 32'd16);
        readStatus(st);
        checkOutput("wr_err_status", st, 32'h101);
        v = '{base: 32'h0000_5000, mode: 0, cycles: 16, done_last: 1'b0, cnt: 4'd2};
        applyStimulus(v);
        writeReg(5'd17, 32'h1);
        readStatus(st);
        checkOutput("wr_err_clear", st, 32'h2);

        $display("[TB] reset during send");
        pushBlock();
        writeReg(5'd16, 32'h1);
        for (int i = 0; i < 7; i++) begin
            pipe_ready = 1'b1;
            tick();
        end
        pipe_ready  = 1'b0;
        checkOutput("mid_data", pipe_data, 32'h0000_5007);
        reset_n     = 1'b0;
        avs_address = 5'd17;
        tick();
        checkOutput("mid_rst_valid", {31'b0, pipe_valid}, 32'h0);
        checkOutput("mid_rst_count", {28'b0, in_count}, 32'h0);
        checkOutput("mid_rst_read", avs_readdata, 32'h0);
        reset_n = 1'b1;
        exp_q.delete();
        readStatus(st);
        checkOutput("mid_rst_status", st, 32'h0);
        v = '{base: 32'h0000_5000, mode: 0, cycles: 16, done_last: 1'b0, cnt: 4'd1};
        applyStimulus(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
